// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the calculator's divide sequencer: state encoding,
// default operand width, and the mode one-hot constants also used by top_ctrl.
package div_ctrl_pkg;

  // Default operand/quotient/remainder width
  localparam int DEFAULT_WIDTH = 8;

  // Mode one-hot constants shared with top_ctrl
  localparam logic [3:0] MODE_ADD = 4'b0001;
  localparam logic [3:0] MODE_SUB = 4'b0010;
  localparam logic [3:0] MODE_MUL = 4'b0100;
  localparam logic [3:0] MODE_DIV = 4'b1000;

  // Divide sequencer states, 3-bit binary encoding
  typedef enum logic [2:0] {
    DIV_IDLE  = 3'd0,
    DIV_LOAD  = 3'd1,
    DIV_ZCHK  = 3'd2,
    DIV_SHIFT = 3'd3,
    DIV_SUB   = 3'd4,
    DIV_TEST  = 3'd5,
    DIV_FIN   = 3'd6,
    DIV_HOLD  = 3'd7
  } div_state_t;

  // Iteration counter width; a single-bit operand still needs a one-bit counter
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/div_ctrl.sv
// Restoring shift-subtract divide sequencer. Drives div_dp with one-hot
// micro-ops, runs WIDTH iterations of shift/subtract/test, and reports a
// one-cycle done pulse (with v on divide-by-zero) back to top_ctrl.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic div_,
  input  logic dz,
  input  logic r_neg,
  output logic ld_ops,
  output logic shl,
  output logic sub,
  output logic rest,
  output logic set_q,
  output logic busy,
  output logic done,
  output logic v
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_t       state;
  div_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             err_q;
  logic             err_nxt;

  // State, iteration counter and error flag registers; reset aborts any operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DIV_IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      err_q <= err_nxt;
    end
  end

  // Next-state and micro-op decode from the registered state (rest/set_q also use r_neg)
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = err_q;
    ld_ops    = 1'b0;
    shl       = 1'b0;
    sub       = 1'b0;
    rest      = 1'b0;
    set_q     = 1'b0;
    done      = 1'b0;
    v         = 1'b0;
    busy      = (state != DIV_IDLE);

    case (state)
      DIV_IDLE: begin
        if (div_) begin
          state_nxt = DIV_LOAD;
        end
      end

      DIV_LOAD: begin
        ld_ops    = 1'b1;
        cnt_nxt   = '0;
        state_nxt = DIV_ZCHK;
      end

      DIV_ZCHK: begin
        if (dz) begin
          err_nxt   = 1'b1;
          state_nxt = DIV_FIN;
        end else begin
          err_nxt   = 1'b0;
          state_nxt = DIV_SHIFT;
        end
      end

      DIV_SHIFT: begin
        shl       = 1'b1;
        state_nxt = DIV_SUB;
      end

      DIV_SUB: begin
        sub       = 1'b1;
        state_nxt = DIV_TEST;
      end

      DIV_TEST: begin
        if (r_neg) begin
          rest = 1'b1;
        end else begin
          set_q = 1'b1;
        end
        if (cnt == CNT_LAST) begin
          state_nxt = DIV_FIN;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
          state_nxt = DIV_SHIFT;
        end
      end

      DIV_FIN: begin
        done      = 1'b1;
        v         = err_q;
        state_nxt = DIV_HOLD;
      end

      DIV_HOLD: begin
        if (!div_) begin
          state_nxt = DIV_IDLE;
        end
      end

      default: begin
        state_nxt = DIV_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Testbench for div_ctrl paired with a behavioural div_dp model. Expected
// quotient/remainder/error results are queued when an operation starts and
// popped when the sequencer pulses done.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  localparam int WIDTH = 8;
  localparam int NORMAL_LAT = 3 * WIDTH + 3;
  localparam int DZ_LAT = 3;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             v;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic div_;
  logic dz;
  logic r_neg;
  logic ld_ops;
  logic shl;
  logic sub;
  logic rest;
  logic set_q;
  logic busy;
  logic done;
  logic v;

  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH:0]   r_reg;
  logic             prev_done;

  exp_t sb[$];
  int   check_count = 0;
  int   error_count = 0;

  // Free-running clock
  always #5 clk = ~clk;

  div_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_   (div_),
    .dz     (dz),
    .r_neg  (r_neg),
    .ld_ops (ld_ops),
    .shl    (shl),
    .sub    (sub),
    .rest   (rest),
    .set_q  (set_q),
    .busy   (busy),
    .done   (done),
    .v      (v)
  );

  // Behavioural divide datapath: R is one bit wider so its MSB is the sign after sub
  always @(posedge clk) begin
    if (ld_ops) begin
      q_reg <= dividend;
      m_reg <= divisor;
      r_reg <= '0;
    end else if (shl) begin
      r_reg <= {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
      q_reg <= q_reg << 1;
    end else if (sub) begin
      r_reg <= r_reg - {1'b0, m_reg};
    end else if (rest) begin
      r_reg <= r_reg + {1'b0, m_reg};
    end else if (set_q) begin
      q_reg[0] <= 1'b1;
    end
  end

  assign dz    = (m_reg == '0);
  assign r_neg = r_reg[WIDTH];

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    assert (actual === expected)
    else begin
      error_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Every-cycle protocol checks: one-hot micro-ops, v only with done, single-cycle done
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      prev_done <= 1'b0;
    end else begin
      check_output("micro_op_onehot", 32'($countones({ld_ops, shl, sub, rest, set_q}) <= 1), 32'd1);
      check_output("v_implies_done", 32'(v & ~done), 32'd0);
      check_output("done_width", 32'(done & prev_done), 32'd0);
      prev_done <= done;
    end
  end

  // Start one divide, optionally drop div_ right after it is accepted, and
  // follow it to done, checking latency, busy, restore count and the result
  task automatic apply_stimulus(input string tag, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input bit drop_div,
                                input int exp_rests);
    exp_t e;
    exp_t got;
    int   cyc = 0;
    int   rests = 0;
    int   late_ops = 0;
    bit   seen = 1'b0;
    int   exp_cyc;

    @(negedge clk);
    dividend = a;
    divisor  = b;
    div_     = 1'b1;
    e.v = (b == '0);
    e.q = (b == '0) ? a : a / b;
    e.r = (b == '0) ? '0 : a % b;
    sb.push_back(e);
    exp_cyc = (b == '0) ? DZ_LAT : NORMAL_LAT;

    @(posedge clk);
    if (drop_div) begin
      #1 div_ = 1'b0;
    end

    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (rest) rests++;
      if (cyc > 1 && (shl | sub | rest | set_q)) late_ops++;
      check_output({tag, "_busy"}, 32'(busy), 32'd1);
      if (done) begin
        seen = 1'b1;
        got = sb.pop_front();
        check_output({tag, "_q"}, 32'(q_reg), 32'(got.q));
        check_output({tag, "_r"}, 32'(r_reg[WIDTH-1:0]), 32'(got.r));
        check_output({tag, "_v"}, 32'(v), 32'(got.v));
      end
    end

    check_output({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (!seen && sb.size() > 0) begin
      void'(sb.pop_front());
    end
    check_output({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    if (exp_rests >= 0) begin
      check_output({tag, "_rest_count"}, 32'(rests), 32'(exp_rests));
    end
    if (b == '0) begin
      check_output({tag, "_ops_after_load"}, 32'(late_ops), 32'd0);
    end
  endtask

  // Release div_ and let the sequencer fall back to IDLE
  task automatic return_idle(input string tag);
    div_ = 1'b0;
    repeat (2) @(negedge clk);
    check_output({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int dones;

    rst      = 1'b1;
    div_     = 1'b0;
    dividend = '0;
    divisor  = '0;

    // Reset state
    #2;
    check_output("reset_outputs", 32'({ld_ops, shl, sub, rest, set_q, busy, done, v}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("post_reset_busy", 32'(busy), 32'd0);

    // 100/7 with div_ dropped during LOAD: run completes, then returns to IDLE
    apply_stimulus("div_100_7", 8'd100, 8'd7, 1'b1, -1);
    repeat (2) @(negedge clk);
    check_output("div_100_7_idle_busy", 32'(busy), 32'd0);

    // Divide by zero
    apply_stimulus("div_5_0", 8'd5, 8'd0, 1'b0, -1);
    return_idle("div_5_0");

    // Dividend smaller than divisor, and divisor of one
    apply_stimulus("div_7_9", 8'd7, 8'd9, 1'b0, 8);
    return_idle("div_7_9");
    apply_stimulus("div_255_1", 8'd255, 8'd1, 1'b0, 0);
    return_idle("div_255_1");

    // Asynchronous reset in cycle 10 of 200/3
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 8'd3;
    div_     = 1'b1;
    sb.push_back('{q: 8'd66, r: 8'd2, v: 1'b0});
    @(posedge clk);
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dones++;
    end
    #2 rst = 1'b1;
    #1;
    check_output("async_reset_outputs", 32'({ld_ops, shl, sub, rest, set_q, busy, done, v}), 32'd0);
    void'(sb.pop_back());
    div_ = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    check_output("aborted_no_done", 32'(dones), 32'd0);
    check_output("aborted_idle_busy", 32'(busy), 32'd0);
    apply_stimulus("div_200_3", 8'd200, 8'd3, 1'b1, -1);
    repeat (2) @(negedge clk);

    // Held div_ never restarts; a one-cycle low re-arms
    apply_stimulus("div_50_6", 8'd50, 8'd6, 1'b0, -1);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    check_output("held_extra_dones", 32'(dones), 32'd0);
    check_output("held_busy", 32'(busy), 32'd1);
    div_ = 1'b0;
    apply_stimulus("div_12_5", 8'd12, 8'd5, 1'b0, -1);
    return_idle("div_12_5");

    check_output("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
